// File: rtl/tx_packet_arbiter.sv
// Shares the host TX byte stream between packet producers, sending one latched packet at a time.
// Define TX_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module tx_packet_arbiter #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned MAX_BYTES = 5,
  parameter int unsigned LEN_W     = 3,
  localparam int unsigned IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_SRC-1:0]             src_req,
  input  logic [NUM_SRC*LEN_W-1:0]       src_len,
  input  logic [NUM_SRC*MAX_BYTES*8-1:0] src_data,
  output logic [NUM_SRC-1:0]             src_done,
  output logic [7:0]                     tx_data,
  output logic                           tx_vld,
  input  logic                           tx_rdy,
  output logic                           busy,
  output logic [IDX_W-1:0]               grant_idx
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [LEN_W-1:0] w_cnt_inc;
  logic [LEN_W-1:0] w_len_raw;
  logic [LEN_W-1:0] w_len_eff;
  logic [7:0]       r_bytes [MAX_BYTES];
  logic [7:0]       r_tx_data;
  logic [7:0]       w_tx_data_nxt;
  logic             r_tx_vld;
  logic             w_tx_vld_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] w_grant_nxt;
  logic [IDX_W-1:0] w_win;
  logic             w_grant_now;
  logic             w_last;

`ifdef TX_ARB_ROUND_ROBIN_EN
  // The last granted index is the round-robin pointer; search starts one past it and wraps.
  always_comb begin
    w_win = r_grant_idx;
    for (int k = int'(NUM_SRC); k >= 1; k--) begin
      int unsigned idx;
      idx = (int'(r_grant_idx) + k) % NUM_SRC;
      if (src_req[IDX_W'(idx)]) w_win = IDX_W'(idx);
    end
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    w_win = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (src_req[IDX_W'(i)]) w_win = IDX_W'(i);
    end
  end
`endif

  // Zero length sends one byte; oversize lengths are clamped to the packet buffer.
  assign w_len_raw = src_len[int'(w_win)*LEN_W +: LEN_W];
  assign w_len_eff = (w_len_raw == '0) ? LEN_W'(1) :
                     (w_len_raw > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : w_len_raw;

  assign w_grant_now = (r_state == S_IDLE) && (|src_req);
  assign w_last      = (r_cnt == (r_len - LEN_W'(1)));
  assign w_cnt_inc   = r_cnt + LEN_W'(1);

  always_comb begin
    src_done = '0;
    if (r_tx_vld && tx_rdy && w_last) src_done[r_grant_idx] = 1'b1;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tx_data_nxt = r_tx_data;
    w_tx_vld_nxt  = r_tx_vld;
    w_busy_nxt    = r_busy;
    w_grant_nxt   = r_grant_idx;
    case (r_state)
      S_IDLE: begin
        if (w_grant_now) begin
          w_state_nxt   = S_SEND;
          w_cnt_nxt     = '0;
          w_tx_data_nxt = src_data[int'(w_win)*MAX_BYTES*8 +: 8];
          w_tx_vld_nxt  = 1'b1;
          w_busy_nxt    = 1'b1;
          w_grant_nxt   = w_win;
        end
      end
      S_SEND: begin
        if (r_tx_vld && tx_rdy) begin
          if (w_last) begin
            w_state_nxt  = S_IDLE;
            w_tx_vld_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
          end else begin
            w_cnt_nxt     = w_cnt_inc;
            w_tx_data_nxt = r_bytes[w_cnt_inc];
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_tx_data   <= '0;
      r_tx_vld    <= 1'b0;
      r_busy      <= 1'b0;
      r_grant_idx <= '0;
      for (int k = 0; k < int'(MAX_BYTES); k++) r_bytes[k] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_vld    <= w_tx_vld_nxt;
      r_busy      <= w_busy_nxt;
      r_grant_idx <= w_grant_nxt;
      // Snapshot the whole packet so source changes during SEND are ignored.
      if (w_grant_now) begin
        r_len <= w_len_eff;
        for (int k = 0; k < int'(MAX_BYTES); k++)
          r_bytes[k] <= src_data[(int'(w_win)*int'(MAX_BYTES) + k)*8 +: 8];
      end
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_vld    = r_tx_vld;
  assign busy      = r_busy;
  assign grant_idx = r_grant_idx;

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Bench for tx_packet_arbiter: directed and random packets against a transaction-level model.
// Honours TX_ARB_ROUND_ROBIN_EN to select the expected arbitration order.
module tb_tx_packet_arbiter;

  localparam int NS = 4;
  localparam int MB = 5;
  localparam int LW = 3;
`ifdef TX_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NS-1:0]     src_req;
  logic [NS*LW-1:0]  src_len;
  logic [NS*MB*8-1:0] src_data;
  logic [NS-1:0]     src_done;
  logic [7:0]        tx_data;
  logic              tx_vld;
  logic              tx_rdy;
  logic              busy;
  logic [1:0]        grant_idx;

  tx_packet_arbiter #(.NUM_SRC(NS), .MAX_BYTES(MB), .LEN_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .src_req(src_req), .src_len(src_len),
    .src_data(src_data), .src_done(src_done), .tx_data(tx_data), .tx_vld(tx_vld),
    .tx_rdy(tx_rdy), .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] pkt_tab [NS][MB];
  int         len_tab [NS];
  int         model_last;
  int         exp_gnt[$];
  logic [7:0] exp_bytes[$];
  int         got_gnt[$];
  logic [7:0] got_bytes[$];
  int         done_cnt [NS];
  int         cyc = 0;
  int         last_done_cyc;
  int         pkt_cnt;
  bit         keep_req = 1'b0;
  bit         rand_rdy = 1'b0;
  logic       prev_vld = 1'b0;
  logic       prev_rdy = 1'b0;
  logic [7:0] prev_data = '0;
  logic       s_vld;
  logic [7:0] s_data;
  logic       s_busy;
  logic [1:0] s_gidx;
  logic [NS-1:0] s_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_len(input int l);
    return (l == 0) ? 1 : ((l > MB) ? MB : l);
  endfunction

  // Next winner among requesting sources, given the previously granted one.
  function automatic int pick(input logic [NS-1:0] mask, input int last);
    int c;
    for (int k = 1; k <= NS; k++) begin
      c = RR ? (last + k) % NS : k - 1;
      if (mask[c]) return c;
    end
    return 0;
  endfunction

  task automatic set_pkt(input int s, input int len, input logic [8*MB-1:0] bytes);
    len_tab[s] = len;
    src_len[s*LW +: LW] = LW'(len);
    for (int k = 0; k < MB; k++) begin
      pkt_tab[s][k] = bytes[(MB-1-k)*8 +: 8];
      src_data[(s*MB+k)*8 +: 8] = pkt_tab[s][k];
    end
  endtask

  task automatic start_batch(input logic [NS-1:0] mask);
    logic [NS-1:0] m;
    int w;
    m = mask;
    exp_gnt.delete();
    exp_bytes.delete();
    while (m != '0) begin
      w = pick(m, model_last);
      exp_gnt.push_back(w);
      m[w] = 1'b0;
      model_last = w;
      for (int k = 0; k < clamp_len(len_tab[w]); k++) exp_bytes.push_back(pkt_tab[w][k]);
    end
    got_bytes.delete();
    got_gnt.delete();
    last_done_cyc = -1;
    for (int i = 0; i < NS; i++) done_cnt[i] = 0;
    src_req = mask;
  endtask

  // One clock: sample at negedge, check handshake rules, then let sources react after the edge.
  task automatic cycle();
    logic [NS-1:0] dm;
    int idx;
    @(negedge clk);
    cyc++;
    s_vld = tx_vld; s_data = tx_data; s_busy = busy; s_gidx = grant_idx; s_done = src_done;
    if (prev_vld && !prev_rdy) begin
      check("stall_vld", 32'(s_vld), 32'(1));
      check("stall_data", 32'(s_data), 32'(prev_data));
    end
    if (s_vld && !prev_vld) begin
      got_gnt.push_back(int'(s_gidx));
      pkt_cnt = 0;
      if (last_done_cyc >= 0) check("bubble", 32'(cyc - last_done_cyc), 32'(2));
    end
    if (s_vld && tx_rdy) begin
      got_bytes.push_back(s_data);
      pkt_cnt++;
    end
    if (s_done != '0) begin
      idx = got_gnt.size() - 1;
      check("done_hs", 32'(s_vld && tx_rdy), 32'(1));
      if (idx >= 0 && idx < exp_gnt.size()) begin
        check("done_src", 32'(s_done), 32'(1) << exp_gnt[idx]);
        check("done_len", 32'(pkt_cnt), 32'(clamp_len(len_tab[exp_gnt[idx]])));
      end else begin
        check("done_unexpected", 32'(s_done), 32'(0));
      end
      for (int i = 0; i < NS; i++) if (s_done[i]) done_cnt[i]++;
      last_done_cyc = cyc;
    end
    prev_vld = s_vld; prev_rdy = tx_rdy; prev_data = s_data;
    dm = s_done;
    @(posedge clk);
    #1;
    if (!keep_req) src_req = src_req & ~dm;
    if (rand_rdy) tx_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic run_batch(input logic [NS-1:0] mask, input int maxcyc);
    int n;
    n = 0;
    start_batch(mask);
    do begin
      cycle();
      n++;
    end while ((src_req != '0 || s_vld) && n < maxcyc);
    check("batch_timeout", 32'(n < maxcyc), 32'(1));
    check("nbytes", 32'(got_bytes.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size(); i++)
      if (i < got_bytes.size()) check($sformatf("byte%0d", i), 32'(got_bytes[i]), 32'(exp_bytes[i]));
    for (int i = 0; i < exp_gnt.size(); i++)
      if (i < got_gnt.size()) check($sformatf("grant%0d", i), 32'(got_gnt[i]), 32'(exp_gnt[i]));
    for (int i = 0; i < NS; i++) check($sformatf("done_cnt%0d", i), 32'(done_cnt[i]), 32'(mask[i]));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_last = 0;
    prev_vld = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed time %0t, required finish before 500000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8*MB-1:0] rb;
    reset_n = 1'b0; src_req = '0; src_len = '0; src_data = '0; tx_rdy = 1'b0;
    model_last = 0;
    for (int s = 0; s < NS; s++) set_pkt(s, 1, '0);
    @(negedge clk);
    check("rst_vld", 32'(tx_vld), 32'(0));
    check("rst_data", 32'(tx_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_gidx", 32'(grant_idx), 32'(0));
    check("rst_done", 32'(src_done), 32'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Single one-byte ack packet.
    set_pkt(3, 1, 40'hA5_00_00_00_00);
    tx_rdy = 1'b1;
    start_batch(4'b1000);
    cycle();
    check("ack_pre_vld", 32'(s_vld), 32'(0));
    check("ack_pre_busy", 32'(s_busy), 32'(0));
    cycle();
    check("ack_vld", 32'(s_vld), 32'(1));
    check("ack_data", 32'(s_data), 32'(8'hA5));
    check("ack_done", 32'(s_done), 32'(4'b1000));
    check("ack_gidx", 32'(s_gidx), 32'(3));
    check("ack_busy", 32'(s_busy), 32'(1));
    cycle();
    check("ack_post_vld", 32'(s_vld), 32'(0));
    check("ack_post_busy", 32'(s_busy), 32'(0));

    // Fire packet with a three-cycle stall right after grant.
    set_pkt(0, 2, 40'h81_17_00_00_00);
    tx_rdy = 1'b0;
    start_batch(4'b0001);
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("fire_stall_vld", 32'(s_vld), 32'(1));
      check("fire_stall_data", 32'(s_data), 32'(8'h81));
      check("fire_stall_done", 32'(s_done), 32'(0));
    end
    tx_rdy = 1'b1;
    cycle();
    check("fire_b0", 32'(s_data), 32'(8'h81));
    check("fire_b0_done", 32'(s_done), 32'(0));
    cycle();
    check("fire_b1", 32'(s_data), 32'(8'h17));
    check("fire_b1_done", 32'(s_done), 32'(1));
    cycle();
    check("fire_post_vld", 32'(s_vld), 32'(0));
    check("fire_done_once", 32'(done_cnt[0]), 32'(1));

    // Contention between src0 and a 5-byte time update on src2.
    set_pkt(0, 1, 40'h11_00_00_00_00);
    set_pkt(2, 5, 40'h40_00_00_01_2C);
    run_batch(4'b0101, 40);

    // src1 and src3 requesting continuously from reset.
    do_reset();
    set_pkt(1, 1, 40'h22_00_00_00_00);
    set_pkt(3, 1, 40'h33_00_00_00_00);
    keep_req = 1'b1;
    start_batch(4'b1010);
    model_last = 0;
    exp_gnt.delete();
    for (int j = 0; j < 4; j++) begin
      exp_gnt.push_back(pick(4'b1010, model_last));
      model_last = exp_gnt[j];
    end
    repeat (8) cycle();
    check("cont_ngrants", 32'(got_gnt.size() >= 4), 32'(1));
    for (int j = 0; j < 4; j++)
      if (j < got_gnt.size()) check($sformatf("cont_grant%0d", j), 32'(got_gnt[j]), 32'(exp_gnt[j]));
    keep_req = 1'b0;
    src_req = '0;
    do_reset();

    // Reset in the middle of a 5-byte packet, then full restart.
    set_pkt(0, 5, 40'hC1_C2_C3_C4_C5);
    tx_rdy = 1'b1;
    start_batch(4'b0001);
    repeat (4) cycle();
    check("mid_b2", 32'(s_data), 32'(8'hC3));
    reset_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(tx_vld), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_done", 32'(src_done), 32'(0));
    @(posedge clk);
    #1;
    check("mid_rst_hold_vld", 32'(tx_vld), 32'(0));
    check("mid_rst_total_done", 32'(done_cnt[0]), 32'(0));
    reset_n = 1'b1;
    model_last = 0;
    prev_vld = 1'b0;
    run_batch(4'b0001, 30);

    // Length edges: zero and oversize.
    set_pkt(1, 0, 40'h5A_5B_5C_5D_5E);
    run_batch(4'b0010, 20);
    set_pkt(2, 7, 40'h01_02_03_04_05);
    run_batch(4'b0100, 30);

    // Random packets, request sets and downstream stalls.
    rand_rdy = 1'b1;
    for (int it = 0; it < 30; it++) begin
      for (int s = 0; s < NS; s++) begin
        rb = {32'($urandom()), 8'($urandom())};
        set_pkt(s, int'($urandom_range(0, 7)), rb);
      end
      run_batch(4'($urandom_range(1, 15)), 400);
    end
    rand_rdy = 1'b0;
    tx_rdy = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
